mem_port_ctrl: RTL and testbench

- Sequencer and arbiter for the single byte-wide RAM port, shared by instruction fetch (IF) and the load/store stage (MEM).
- Turns each word, halfword or byte request into consecutive byte cycles on the RAM.
- Assembles little-endian read data and returns it with a one-cycle done pulse.
- Requesters hold their request until done; the pipeline stall control holds the stages meanwhile.

---
 rtl/mem_port_ctrl.sv | 259 +++++++++++++++++++++++++
 tb/tb_mem_port_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: sequencer and arbiter for the single byte-wide RAM port shared by
// instruction fetch (IF) and the load/store stage (MEM).
//
// Each word/halfword/byte request is turned into consecutive byte cycles on the RAM.
// Read data is assembled little-endian and returned with a one-cycle done pulse.
// MEM has priority over IF. In a cycle where a done pulse is showing, no new request
// is accepted, so a requester that still holds req through its done cycle is not
// serviced twice.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   if_req/if_addr/if_flush  IF 32-bit read request; flush aborts an IF read in flight
//   if_done/if_data          IF completion pulse and fetched word (registered)
//   mem_req/mem_we/mem_width/mem_addr/mem_wdata   MEM load/store request
//   mem_done/mem_rdata       MEM completion pulse and zero-extended load data (registered)
//   ram_a/ram_wr/ram_dout    RAM address, write strobe, write byte (decoded from state)
//   ram_din                  RAM read byte, valid one cycle after its address
//
// Optional build macro MEMCTRL_STAT_EN adds stat_conflict, a wrapping count of cycles
// in which IF is requesting while the port is busy with, or granted to, MEM.
module mem_port_ctrl #(
    parameter int unsigned RAM_AW = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    input  logic              if_flush,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_width,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
`ifdef MEMCTRL_STAT_EN
    output logic [31:0]       stat_conflict,
`endif
    output logic [RAM_AW-1:0] ram_a,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
);

    localparam int unsigned DW    = 32;
    localparam int unsigned BW    = 8;
    localparam int unsigned CNT_W = 3;

    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_MEM = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   n_q, n_d;
    logic [RAM_AW-1:0]  addr_q, addr_d;
    logic [DW-1:0]      wdata_q, wdata_d;
    logic [DW-1:0]      rbuf_q, rbuf_d;
    logic               owner_q, owner_d;
    logic               if_done_q, if_done_d;
    logic               mem_done_q, mem_done_d;
    logic [DW-1:0]      if_data_q, if_data_d;
    logic [DW-1:0]      mem_rdata_q, mem_rdata_d;

    logic               done_blk_c;
    logic [1:0]         lane_c;
    logic [DW-1:0]      asm_c;
    logic               unused_addr_c;

    // Upper request address bits lie outside the RAM and are dropped.
    assign unused_addr_c = ^{if_addr[31:RAM_AW], mem_addr[31:RAM_AW]};

    // Byte count of a MEM access.
    function automatic logic [CNT_W-1:0] width_bytes(input logic [1:0] w);
        case (w)
            2'b00:   return CNT_W'(1);
            2'b01:   return CNT_W'(2);
            default: return CNT_W'(4);
        endcase
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            n_q         <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rbuf_q      <= '0;
            owner_q     <= OWN_IF;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rbuf_q      <= rbuf_d;
            owner_q     <= owner_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    // Byte at cnt-1 arrives now; lanes not yet written in rbuf are still zero.
    always_comb begin
        lane_c = 2'(cnt_q - CNT_W'(1));
        asm_c  = rbuf_q | (DW'(ram_din) << {lane_c, 3'b000});
    end

    // Next-state, request latching and completion.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rbuf_d      = rbuf_q;
        owner_d     = owner_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        done_blk_c  = if_done_q | mem_done_q;

        case (state_q)
            ST_IDLE: begin
                if (!done_blk_c) begin
                    if (mem_req) begin
                        owner_d = OWN_MEM;
                        addr_d  = mem_addr[RAM_AW-1:0];
                        n_d     = width_bytes(mem_width);
                        wdata_d = mem_wdata;
                        rbuf_d  = '0;
                        cnt_d   = '0;
                        state_d = mem_we ? ST_WRITE : ST_READ;
                    end else if (if_req && !if_flush) begin
                        owner_d = OWN_IF;
                        addr_d  = if_addr[RAM_AW-1:0];
                        n_d     = CNT_W'(4);
                        rbuf_d  = '0;
                        cnt_d   = '0;
                        state_d = ST_READ;
                    end
                end
            end

            ST_READ: begin
                if (owner_q == OWN_IF && if_flush) begin
                    // Branch flush: drop the fetch without a done pulse.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    if (cnt_q != '0) begin
                        rbuf_d = asm_c;
                    end
                    if (cnt_q == n_q) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        if (owner_q == OWN_MEM) begin
                            mem_done_d  = 1'b1;
                            mem_rdata_d = asm_c;
                        end else begin
                            if_done_d = 1'b1;
                            if_data_d = asm_c;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_WRITE: begin
                if (cnt_q == n_q - CNT_W'(1)) begin
                    state_d    = ST_IDLE;
                    cnt_d      = '0;
                    mem_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // RAM strobes decode from state so reset drops ram_wr without a clock edge.
    always_comb begin
        ram_a    = '0;
        ram_wr   = 1'b0;
        ram_dout = '0;
        case (state_q)
            ST_READ: begin
                if (cnt_q < n_q) begin
                    ram_a = addr_q + RAM_AW'(cnt_q);
                end
            end
            ST_WRITE: begin
                ram_a    = addr_q + RAM_AW'(cnt_q);
                ram_wr   = 1'b1;
                ram_dout = BW'(wdata_q >> {cnt_q[1:0], 3'b000});
            end
            default: begin
                ram_a = '0;
            end
        endcase
    end

    assign if_done   = if_done_q;
    assign if_data   = if_data_q;
    assign mem_done  = mem_done_q;
    assign mem_rdata = mem_rdata_q;

`ifdef MEMCTRL_STAT_EN
    logic [31:0] stat_q, stat_d;
    logic        mem_owns_c;

    // IF stalled behind MEM: MEM owns an access in flight or is granted this edge.
    always_comb begin
        mem_owns_c = 1'b0;
        stat_d     = stat_q;
        if (state_q == ST_IDLE) begin
            mem_owns_c = mem_req & ~if_done_q & ~mem_done_q;
        end else begin
            mem_owns_c = (owner_q == OWN_MEM);
        end
        if (if_req && mem_owns_c) begin
            stat_d = stat_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign stat_conflict = stat_q;
`endif

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Testbench for mem_port_ctrl: cycle-by-cycle vector table for the fetch, store,
// arbitration and address-wrap sequences, plus hand-written flush and reset sequences.
module tb_mem_port_ctrl;

    localparam int unsigned RAM_AW = 17;
    localparam logic [31:0] W100   = 32'h0010_0513;
    localparam logic [31:0] W000   = 32'h3322_115A;

    logic              clk;
    logic              rst;
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_flush;
    logic              if_done;
    logic [31:0]       if_data;
    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_width;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_done;
    logic [31:0]       mem_rdata;
`ifdef MEMCTRL_STAT_EN
    logic [31:0]       stat_conflict;
`endif
    logic [RAM_AW-1:0] ram_a;
    logic              ram_wr;
    logic [7:0]        ram_dout;
    logic [7:0]        ram_din;

    logic [7:0] ram [0:(1<<RAM_AW)-1];

    int n_vec  = 0;
    int n_fail = 0;

    mem_port_ctrl #(.RAM_AW(RAM_AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_done   (if_done),
        .if_data   (if_data),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_width (mem_width),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_done  (mem_done),
        .mem_rdata (mem_rdata),
`ifdef MEMCTRL_STAT_EN
        .stat_conflict(stat_conflict),
`endif
        .ram_a     (ram_a),
        .ram_wr    (ram_wr),
        .ram_dout  (ram_dout),
        .ram_din   (ram_din)
    );

    always #5 clk = ~clk;

    // Synchronous byte RAM: read data valid one cycle after the address.
    always @(posedge clk) begin
        ram_din <= ram[ram_a];
        if (ram_wr) ram[ram_a] = ram_dout;
    end

    typedef struct {
        string             nm;
        logic              if_req;
        logic [31:0]       if_addr;
        logic              mem_req;
        logic              mem_we;
        logic [1:0]        mem_width;
        logic [31:0]       mem_addr;
        logic [31:0]       mem_wdata;
        logic              chk_a;
        logic [RAM_AW-1:0] ram_a;
        logic              ram_wr;
        logic [7:0]        ram_dout;
        logic              if_done;
        logic [31:0]       if_data;
        logic              mem_done;
        logic [31:0]       mem_rdata;
    } vec_t;

    vec_t vecs[$];

    logic        c_ifr;
    logic [31:0] c_ifa;
    logic        c_mr;
    logic        c_mw;
    logic [1:0]  c_mwid;
    logic [31:0] c_ma;
    logic [31:0] c_md;

    function automatic void in_set(input logic ifr, input logic [31:0] ifa, input logic mr,
                                   input logic mw, input logic [1:0] mwid,
                                   input logic [31:0] ma, input logic [31:0] md);
        c_ifr = ifr; c_ifa = ifa; c_mr = mr; c_mw = mw; c_mwid = mwid; c_ma = ma; c_md = md;
    endfunction

    // One cycle: inputs for the coming edge, outputs expected in this cycle.
    function automatic void push(input string nm, input logic ca, input logic [31:0] ea,
                                 input logic ew, input logic [7:0] ed,
                                 input logic eid, input logic [31:0] eidat,
                                 input logic emd, input logic [31:0] emdat);
        vec_t v;
        v.nm = nm;
        v.if_req = c_ifr; v.if_addr = c_ifa; v.mem_req = c_mr; v.mem_we = c_mw;
        v.mem_width = c_mwid; v.mem_addr = c_ma; v.mem_wdata = c_md;
        v.chk_a = ca; v.ram_a = RAM_AW'(ea); v.ram_wr = ew; v.ram_dout = ed;
        v.if_done = eid; v.if_data = eidat; v.mem_done = emd; v.mem_rdata = emdat;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic chk_vec(input vec_t v);
        logic ok;
        ok = (if_done === v.if_done) && (if_data === v.if_data) &&
             (mem_done === v.mem_done) && (mem_rdata === v.mem_rdata) &&
             (ram_wr === v.ram_wr);
        if (v.chk_a && (ram_a !== v.ram_a)) ok = 1'b0;
        if (v.ram_wr && (ram_dout !== v.ram_dout)) ok = 1'b0;
        n_vec++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got a=%h wr=%b dout=%h ifd=%b ifdata=%h md=%b mdata=%h; want a=%h wr=%b dout=%h ifd=%b ifdata=%h md=%b mdata=%h",
                     v.nm, ram_a, ram_wr, ram_dout, if_done, if_data, mem_done, mem_rdata,
                     v.ram_a, v.ram_wr, v.ram_dout, v.if_done, v.if_data, v.mem_done, v.mem_rdata);
        end
    endtask

    task automatic drive_idle();
        if_req = 0; if_addr = 0; if_flush = 0;
        mem_req = 0; mem_we = 0; mem_width = 0; mem_addr = 0; mem_wdata = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, limit %0d", 1_000_000);
        $fatal(1);
    end

    initial begin
        int  n;
        logic got;
        logic seen;

        clk = 0;
        rst = 0;
        drive_idle();
        for (int i = 0; i < (1 << RAM_AW); i++) ram[i] = 8'h00;
        ram[17'h00100] = 8'h13; ram[17'h00101] = 8'h05;
        ram[17'h00102] = 8'h10; ram[17'h00103] = 8'h00;
        ram[17'h0001F] = 8'h83;
        ram[17'h1FFFF] = 8'hA5;
        ram[17'h00000] = 8'h5A; ram[17'h00001] = 8'h11;
        ram[17'h00002] = 8'h22; ram[17'h00003] = 8'h33;

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        chk("rst_ram_wr", 32'(ram_wr), 0);
        chk("rst_ram_a", 32'(ram_a), 0);
        chk("rst_ram_dout", 32'(ram_dout), 0);
        chk("rst_if_done", 32'(if_done), 0);
        chk("rst_if_data", if_data, 0);
        chk("rst_mem_done", 32'(mem_done), 0);
        chk("rst_mem_rdata", mem_rdata, 0);
`ifdef MEMCTRL_STAT_EN
        chk("rst_stat", stat_conflict, 0);
`endif
        @(negedge clk); rst = 1;

        // IF word fetch at 0x100
        in_set(1, 32'h100, 0, 0, 2'b00, 0, 0);
        push("if_idle",  0, 0,      0, 0, 0, 0,    0, 0);
        push("if_b0",    1, 'h100,  0, 0, 0, 0,    0, 0);
        push("if_b1",    1, 'h101,  0, 0, 0, 0,    0, 0);
        push("if_b2",    1, 'h102,  0, 0, 0, 0,    0, 0);
        push("if_b3",    1, 'h103,  0, 0, 0, 0,    0, 0);
        push("if_last",  0, 0,      0, 0, 0, 0,    0, 0);
        push("if_done",  0, 0,      0, 0, 1, W100, 0, 0);
        in_set(0, 0, 0, 0, 2'b00, 0, 0);
        push("if_hold",  0, 0,      0, 0, 0, W100, 0, 0);

        // MEM word store 0xDEADBEEF at 0x200
        in_set(0, 0, 1, 1, 2'b10, 32'h200, 32'hDEAD_BEEF);
        push("st_idle",  0, 0,      0, 0,     0, W100, 0, 0);
        push("st_b0",    1, 'h200,  1, 8'hEF, 0, W100, 0, 0);
        push("st_b1",    1, 'h201,  1, 8'hBE, 0, W100, 0, 0);
        push("st_b2",    1, 'h202,  1, 8'hAD, 0, W100, 0, 0);
        push("st_b3",    1, 'h203,  1, 8'hDE, 0, W100, 0, 0);
        push("st_done",  0, 0,      0, 0,     0, W100, 1, 0);
        in_set(0, 0, 0, 0, 2'b00, 0, 0);
        push("st_hold",  0, 0,      0, 0,     0, W100, 0, 0);

        // IF and MEM byte load raised together; MEM first, then IF
        in_set(1, 32'h100, 1, 0, 2'b00, 32'h1F, 0);
        push("arb_idle",  0, 0,     0, 0, 0, W100, 0, 0);
        push("arb_mb0",   1, 'h1F,  0, 0, 0, W100, 0, 0);
        push("arb_mlast", 0, 0,     0, 0, 0, W100, 0, 0);
        push("arb_mdone", 0, 0,     0, 0, 0, W100, 1, 32'h83);
        in_set(1, 32'h100, 0, 0, 2'b00, 0, 0);
        push("arb_blk",   0, 0,     0, 0, 0, W100, 0, 32'h83);
        push("arb_ib0",   1, 'h100, 0, 0, 0, W100, 0, 32'h83);
        push("arb_ib1",   1, 'h101, 0, 0, 0, W100, 0, 32'h83);
        push("arb_ib2",   1, 'h102, 0, 0, 0, W100, 0, 32'h83);
        push("arb_ib3",   1, 'h103, 0, 0, 0, W100, 0, 32'h83);
        push("arb_ilast", 0, 0,     0, 0, 0, W100, 0, 32'h83);
        push("arb_idone", 0, 0,     0, 0, 1, W100, 0, 32'h83);
        in_set(0, 0, 0, 0, 2'b00, 0, 0);
        push("arb_hold",  0, 0,     0, 0, 0, W100, 0, 32'h83);

        // Halfword load wrapping at the top of the RAM
        in_set(0, 0, 1, 0, 2'b01, 32'h0001_FFFF, 0);
        push("hw_idle",  0, 0,        0, 0, 0, W100, 0, 32'h83);
        push("hw_b0",    1, 'h1FFFF,  0, 0, 0, W100, 0, 32'h83);
        push("hw_b1",    1, 'h00000,  0, 0, 0, W100, 0, 32'h83);
        push("hw_last",  0, 0,        0, 0, 0, W100, 0, 32'h83);
        push("hw_done",  0, 0,        0, 0, 0, W100, 1, 32'h5AA5);
        in_set(0, 0, 0, 0, 2'b00, 0, 0);
        push("hw_hold",  0, 0,        0, 0, 0, W100, 0, 32'h5AA5);

        foreach (vecs[i]) begin
            @(negedge clk);
            if_req = vecs[i].if_req; if_addr = vecs[i].if_addr; if_flush = 0;
            mem_req = vecs[i].mem_req; mem_we = vecs[i].mem_we;
            mem_width = vecs[i].mem_width; mem_addr = vecs[i].mem_addr;
            mem_wdata = vecs[i].mem_wdata;
            chk_vec(vecs[i]);
        end

`ifdef MEMCTRL_STAT_EN
        chk("stat_after_arb", stat_conflict, 32'd3);
`endif

        // Flush in the second READ cycle of a fetch
        @(negedge clk); drive_idle(); if_req = 1; if_addr = 32'h100;
        @(negedge clk);
        chk("fl_r1_a", 32'(ram_a), 32'h100);
        @(negedge clk);
        chk("fl_r2_a", 32'(ram_a), 32'h101);
        if_flush = 1; if_req = 0;
        @(negedge clk); if_flush = 0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (if_done) seen = 1;
            @(negedge clk);
        end
        chk("fl_no_done", 32'(seen), 0);
        chk("fl_data_hold", if_data, W100);

        // Flush in IDLE blocks one cycle, then fetch at 0x0 completes
        if_req = 1; if_addr = 32'h0; if_flush = 1;
        n = 0; got = 0;
        while (n < 12 && !got) begin
            @(negedge clk);
            n++;
            if (n == 1) if_flush = 0;
            if (if_done) got = 1;
        end
        chk("fl_fetch_latency", 32'(n), 32'd7);
        chk("fl_fetch_data", if_data, W000);
        @(negedge clk); if_req = 0;

        // Reset asserted mid-store
        @(negedge clk);
        mem_req = 1; mem_we = 1; mem_width = 2'b10; mem_addr = 32'h300; mem_wdata = 32'h1122_3344;
        @(negedge clk);
        chk("rs_wr_b0", 32'(ram_wr), 1);
        @(negedge clk);
        chk("rs_dout_b1", 32'(ram_dout), 32'h33);
        @(posedge clk); #2;
        rst = 0;
        #1;
        chk("rs_ram_wr", 32'(ram_wr), 0);
        chk("rs_ram_a", 32'(ram_a), 0);
        chk("rs_ram_dout", 32'(ram_dout), 0);
        chk("rs_if_data", if_data, 0);
        chk("rs_mem_done", 32'(mem_done), 0);
        chk("rs_mem_rdata", mem_rdata, 0);
`ifdef MEMCTRL_STAT_EN
        chk("rs_stat", stat_conflict, 0);
`endif
        drive_idle();
        @(negedge clk); @(negedge clk); rst = 1;

        // Byte load after reset release
        @(negedge clk);
        mem_req = 1; mem_we = 0; mem_width = 2'b00; mem_addr = 32'h1F;
        n = 0; got = 0;
        while (n < 12 && !got) begin
            @(negedge clk);
            n++;
            if (mem_done) got = 1;
        end
        chk("rs_load_latency", 32'(n), 32'd3);
        chk("rs_load_data", mem_rdata, 32'h83);
        @(negedge clk); drive_idle();
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
